// File: rtl/mult_initiator_pkg.sv
// -----------------------------------------------------------------------------
// mult_initiator_pkg
// Shared definitions for the floating-point multiplier initiator:
//   - state_t         : initiator FSM states (IDLE, ISSUE, HOLD)
//   - QNAN            : IEEE-754 single-precision quiet NaN, returned on timeout
//   - DW_DEFAULT      : default operand/result width
//   - TIMEOUT_DEFAULT : default number of ISSUE cycles before giving up
// -----------------------------------------------------------------------------
package mult_initiator_pkg;

  localparam int          DW_DEFAULT      = 32;
  localparam int          TIMEOUT_DEFAULT = 64;
  localparam logic [31:0] QNAN            = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/mult_initiator_if.sv
// -----------------------------------------------------------------------------
// mult_initiator_if
// Bundles the three handshakes around the initiator:
//   req_*  : operand pair offered by the producer (valid/ready)
//   mul_*  : strobes/operands towards the multiplier, done pulse and product back
//   rsp_*  : captured product and error flag towards the consumer (valid/ready)
// Modports:
//   master : the initiator itself
//   slave  : its environment (producer, multiplier, consumer)
// -----------------------------------------------------------------------------
interface mult_initiator_if
  import mult_initiator_pkg::*;
#(
  parameter int DW = DW_DEFAULT
);

  logic          req_valid;
  logic          req_ready;
  logic [DW-1:0] req_a;
  logic [DW-1:0] req_b;

  logic          mul_x_rdy;
  logic          mul_y_rdy;
  logic [DW-1:0] mul_x_data;
  logic [DW-1:0] mul_y_data;
  logic          mul_done;
  logic [DW-1:0] mul_z_data;

  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          rsp_err;

  modport master (
    input  req_valid, req_a, req_b, mul_done, mul_z_data, rsp_ready,
    output req_ready, mul_x_rdy, mul_y_rdy, mul_x_data, mul_y_data,
           rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    output req_valid, req_a, req_b, mul_done, mul_z_data, rsp_ready,
    input  req_ready, mul_x_rdy, mul_y_rdy, mul_x_data, mul_y_data,
           rsp_valid, rsp_data, rsp_err
  );

endinterface

// File: rtl/mult_timeout_ctr.sv
// -----------------------------------------------------------------------------
// mult_timeout_ctr
// Counts the cycles a transaction spends waiting on the multiplier.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   load     : restart the count (request accepted)
//   enable   : one waiting cycle elapses
//   expire   : high in the LIMIT-th enabled cycle since load
// Only instantiated when MULT_TIMEOUT_EN is defined.
// -----------------------------------------------------------------------------
module mult_timeout_ctr #(
  parameter int unsigned LIMIT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic enable,
  output logic expire
);

  logic [15:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 16'd1;
    end
  end

  // count holds the number of waiting cycles already completed, so the
  // LIMIT-th waiting cycle is the one in which count equals LIMIT-1.
  assign expire = enable && (count == 16'(LIMIT - 1));

endmodule

// File: rtl/mult_initiator.sv
// -----------------------------------------------------------------------------
// mult_initiator
// Accepts an IEEE-754 operand pair, presents it to a handshaked multiplier,
// waits for the done pulse and holds the product until the consumer takes it.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   bus       : mult_initiator_if.master (req_*, mul_*, rsp_* handshakes)
//   txn_count : number of responses handed to the consumer (wraps at 16 bits)
// Configuration:
//   MULT_TIMEOUT_EN : when defined, a transaction that waits TIMEOUT_CYCLES
//                     ISSUE cycles without mul_done completes with rsp_err=1
//                     and a quiet-NaN result; otherwise ISSUE waits forever.
// -----------------------------------------------------------------------------
module mult_initiator
  import mult_initiator_pkg::*;
#(
  parameter int DW             = DW_DEFAULT,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  mult_initiator_if.master       bus,
  output logic [15:0]            txn_count
);

  state_t        state;
  logic          req_ready;
  logic          mul_rdy;
  logic [DW-1:0] x_data;
  logic [DW-1:0] y_data;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;
  logic          rsp_err;
  logic          accept;
  logic          timeout_expire;

  // req_ready is only ever high in IDLE, so this is the request handshake.
  assign accept = (state == IDLE) && req_ready && bus.req_valid;

`ifdef MULT_TIMEOUT_EN
  mult_timeout_ctr #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .clk    (clk),
    .rst    (rst),
    .load   (accept),
    .enable (state == ISSUE),
    .expire (timeout_expire)
  );
`else
  assign timeout_expire = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the datapath registers are reset as well, so the outputs never
      // show stale operands or products from before the reset.
      state     <= IDLE;
      req_ready <= 1'b0;
      mul_rdy   <= 1'b0;
      x_data    <= '0;
      y_data    <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      txn_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            x_data    <= bus.req_a;
            y_data    <= bus.req_b;
            mul_rdy   <= 1'b1;
            req_ready <= 1'b0;
            state     <= ISSUE;
          end else begin
            // Also covers the first cycle after reset, when req_ready is low.
            req_ready <= 1'b1;
          end
        end

        ISSUE: begin
          // A product arriving in the expiry cycle takes priority over the timeout.
          if (bus.mul_done) begin
            rsp_data  <= bus.mul_z_data;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            mul_rdy   <= 1'b0;
            state     <= HOLD;
          end else if (timeout_expire) begin
            rsp_data  <= DW'(QNAN);
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            mul_rdy   <= 1'b0;
            state     <= HOLD;
          end
        end

        HOLD: begin
          // req_ready rises with the return to IDLE, one cycle after the
          // response handshake, so no request is taken in the same cycle.
          if (bus.rsp_ready) begin
            rsp_valid <= 1'b0;
            txn_count <= txn_count + 16'd1;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready  = req_ready;
  assign bus.mul_x_rdy  = mul_rdy;
  assign bus.mul_y_rdy  = mul_rdy;
  assign bus.mul_x_data = x_data;
  assign bus.mul_y_data = y_data;
  assign bus.rsp_valid  = rsp_valid;
  assign bus.rsp_data   = rsp_data;
  assign bus.rsp_err    = rsp_err;

endmodule

// File: tb/tb_mult_initiator.sv
// -----------------------------------------------------------------------------
// tb_mult_initiator
// Drives mult_initiator through its producer, multiplier and consumer
// handshakes. Expected responses are queued when a request is issued and
// compared when the consumer takes the response. Timeout scenarios are
// compiled in only when MULT_TIMEOUT_EN is defined.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mult_initiator;
  import mult_initiator_pkg::*;

  localparam int DW = 32;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] txn_count;

  mult_initiator_if #(.DW(DW)) bus ();

  mult_initiator #(
    .DW             (DW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .txn_count (txn_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } rsp_t;

  rsp_t        exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] exp_count;

  // Multiplier model controls.
  bit mul_en  = 1'b1;
  int mul_lat = 0;
  int issue_cnt = 0;
  bit stray   = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Products for the table vectors are exact single-precision results; other
  // operand pairs get a distinct stand-in value, since the initiator only
  // forwards whatever the multiplier returns.
  function automatic logic [31:0] fp_model(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'h4003_3333, 32'h3F82_8F5C}: return 32'h4005_D2F1;
      {32'h4000_0000, 32'h4040_0000}: return 32'h40C0_0000;
      {32'h3FC0_0000, 32'h3FC0_0000}: return 32'h4010_0000;
      {32'hC000_0000, 32'h3F00_0000}: return 32'hBF80_0000;
      default:                        return a ^ {b[15:0], b[31:16]};
    endcase
  endfunction

  // Multiplier model: pulses mul_done once the strobes have been high for
  // mul_lat+1 cycles; with stray set it also pulses mul_done (with a junk
  // product) whenever the strobes are low.
  initial begin
    bus.mul_done   = 1'b0;
    bus.mul_z_data = '0;
    forever begin
      @(negedge clk);
      bus.mul_done = 1'b0;
      if (bus.mul_x_rdy && bus.mul_y_rdy) begin
        if (mul_en && issue_cnt >= mul_lat) begin
          bus.mul_done   = 1'b1;
          bus.mul_z_data = fp_model(bus.mul_x_data, bus.mul_y_data);
        end
        issue_cnt++;
      end else begin
        issue_cnt = 0;
        if (stray) begin
          bus.mul_done   = 1'b1;
          bus.mul_z_data = 32'hDEAD_BEEF;
        end
      end
    end
  end

  // Called at a falling edge; returns at the falling edge of the first ISSUE cycle.
  task automatic send_req(input logic [31:0] a, input logic [31:0] b, input bit exp_err);
    int   n = 0;
    rsp_t e;
    while (!bus.req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("req_ready_wait", bus.req_ready, 1);
    bus.req_valid = 1'b1;
    bus.req_a     = a;
    bus.req_b     = b;
    e.data = exp_err ? QNAN : fp_model(a, b);
    e.err  = exp_err;
    exp_q.push_back(e);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("issue_strobes", {bus.mul_x_rdy, bus.mul_y_rdy}, 2'b11);
    check("issue_x_data", bus.mul_x_data, a);
    check("issue_y_data", bus.mul_y_data, b);
    check("issue_req_ready", bus.req_ready, 0);
  endtask

  // Waits for a response, stalls the consumer for 'hold' cycles, then takes it.
  task automatic get_rsp(input int hold);
    int          n = 0;
    rsp_t        e;
    logic [31:0] d0;
    bit          stable = 1'b1;
    while (!bus.rsp_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("rsp_valid_wait", bus.rsp_valid, 1);
    check("sb_nonempty", exp_q.size() != 0, 1);
    if (!bus.rsp_valid || exp_q.size() == 0) return;
    e  = exp_q.pop_front();
    d0 = bus.rsp_data;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!bus.rsp_valid || bus.rsp_data !== d0 || bus.req_ready) stable = 1'b0;
    end
    if (hold > 0) check("hold_stable", stable, 1);
    check("rsp_data", bus.rsp_data, e.data);
    check("rsp_err", bus.rsp_err, e.err);
    bus.rsp_ready = 1'b1;
    check("no_accept_in_hold", bus.req_ready, 0);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    exp_count++;
    check("rsp_dropped", bus.rsp_valid, 0);
    check("req_ready_after_hold", bus.req_ready, 1);
    check("txn_count", txn_count, exp_count);
  endtask

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int  n;
    bit  seen;
    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;
    exp_count     = '0;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_strobes", {bus.mul_x_rdy, bus.mul_y_rdy}, 2'b00);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_err", bus.rsp_err, 0);
    check("rst_rsp_data", bus.rsp_data, 0);
    check("rst_x_data", bus.mul_x_data, 0);
    check("rst_y_data", bus.mul_y_data, 0);
    check("rst_txn_count", txn_count, 0);
    rst = 1'b0;
    @(negedge clk);
    check("req_ready_after_reset", bus.req_ready, 1);

    // Reference vector, multiplier answers in its third cycle.
    mul_lat = 2;
    send_req(32'h4003_3333, 32'h3F82_8F5C, 1'b0);
    get_rsp(0);

    // Consumer stalls 5 cycles while stray done pulses hit HOLD and IDLE.
    mul_lat = 0;
    send_req(32'h4000_0000, 32'h4040_0000, 1'b0);
    stray = 1'b1;
    get_rsp(5);
    repeat (2) @(negedge clk);
    stray = 1'b0;
    @(negedge clk);
    check("stray_idle_rsp_valid", bus.rsp_valid, 0);
    check("stray_idle_strobes", {bus.mul_x_rdy, bus.mul_y_rdy}, 2'b00);
    check("stray_idle_txn_count", txn_count, exp_count);

    // Back-to-back request with a one-cycle multiplier latency.
    mul_lat = 1;
    send_req(32'h3FC0_0000, 32'h3FC0_0000, 1'b0);
    get_rsp(1);

    // Request offered while busy is held off and operands stay put.
    mul_en = 1'b0;
    send_req(32'hC000_0000, 32'h3F00_0000, 1'b0);
    bus.req_valid = 1'b1;
    bus.req_a     = 32'h1234_5678;
    bus.req_b     = 32'h9ABC_DEF0;
    repeat (3) @(negedge clk);
    check("holdoff_x_data", bus.mul_x_data, 32'hC000_0000);
    check("holdoff_y_data", bus.mul_y_data, 32'h3F00_0000);
    check("holdoff_strobes", {bus.mul_x_rdy, bus.mul_y_rdy}, 2'b11);
    bus.req_valid = 1'b0;
    mul_en = 1'b1;
    get_rsp(0);

`ifdef MULT_TIMEOUT_EN
    // Multiplier never answers: exactly TO ISSUE cycles, then a NaN error.
    mul_en = 1'b0;
    send_req(32'h4080_0000, 32'h4100_0000, 1'b1);
    n = 1;
    while (bus.mul_x_rdy && n < 50) begin
      @(negedge clk);
      if (bus.mul_x_rdy) n++;
    end
    check("timeout_issue_cycles", n, TO);
    get_rsp(0);
    mul_en = 1'b1;
`endif

    // Multiplier answers in the last allowed ISSUE cycle: product wins.
    mul_lat = TO - 1;
    send_req(32'h4040_0000, 32'h4000_0000, 1'b0);
    get_rsp(0);

    // Reset during ISSUE drops the transaction.
    mul_en = 1'b0;
    send_req(32'h3F80_0000, 32'h3F80_0000, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("midrst_strobes", {bus.mul_x_rdy, bus.mul_y_rdy}, 2'b00);
    check("midrst_rsp_valid", bus.rsp_valid, 0);
    check("midrst_req_ready", bus.req_ready, 0);
    check("midrst_txn_count", txn_count, 0);
    exp_q.delete();
    exp_count = '0;
    @(negedge clk);
    rst    = 1'b0;
    mul_en = 1'b1;
    seen   = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (bus.rsp_valid) seen = 1'b1;
    end
    check("midrst_no_rsp", seen, 0);
    check("midrst_count_kept", txn_count, exp_count);

    // Counter wrap: preset to 0xFFFF, one more transaction.
    force dut.txn_count = 16'hFFFF;
    @(negedge clk);
    release dut.txn_count;
    @(negedge clk);
    check("wrap_preset", txn_count, 16'hFFFF);
    exp_count = 16'hFFFF;
    mul_lat = 0;
    send_req(32'h4000_0000, 32'h4040_0000, 1'b0);
    get_rsp(0);
    check("wrap_zero", txn_count, 16'h0000);

    check("sb_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
